// File: rtl/codec_i2s_intf.sv
// I2S master link to the CS4272: derives MCLK/SCLK/LRCLK/RSTn from clk, receives and transmits DW-bit samples.
// Optional build macro CODEC_LOOPBACK_EN: the transmit registers reload from the received words (echo path).
module codec_i2s_intf #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SDout,
  input  logic [DW-1:0] lft_out,
  input  logic [DW-1:0] rht_out,
  output logic          MCLK,
  output logic          SCLK,
  output logic          LRCLK,
  output logic          RSTn,
  output logic          SDin,
  output logic [DW-1:0] lft_in,
  output logic [DW-1:0] rht_in,
  output logic          vld
);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [4:0] K_LAST  = 5'(DW);

  logic [9:0]    cnt_reg;
  logic [1:0]    state_reg;
  logic [4:0]    k;
  logic [4:0]    tx_idx;
  logic          sclk_rise;
  logic          sclk_fall;
  logic          frame_start;
  logic          rx_win;
  logic          tx_win;
  logic          rx_done;
  logic [DW-1:0] sr_word [2];
  logic [DW-1:0] tx_word [2];
  logic [DW-1:0] tx_src  [2];

  assign k           = cnt_reg[8:4];
  assign tx_idx      = 5'(DW - 1) - k;
  assign sclk_rise   = (cnt_reg[3:0] == 4'h7);
  assign sclk_fall   = (cnt_reg[3:0] == 4'hF);
  assign frame_start = (cnt_reg == 10'h3FF);
  assign rx_win      = (k != 5'd0) && (k <= K_LAST);
  assign tx_win      = (k < K_LAST);
  assign rx_done     = sclk_rise && cnt_reg[9] && (k == K_LAST) && (state_reg == ST_RUN);

`ifdef CODEC_LOOPBACK_EN
  assign tx_src[0] = lft_in;
  assign tx_src[1] = rht_in;
`else
  assign tx_src[0] = lft_out;
  assign tx_src[1] = rht_out;
`endif

  // Clock outputs are registered copies of the next counter value, so they track cnt bit-exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 10'd0;
      MCLK    <= 1'b0;
      SCLK    <= 1'b0;
      LRCLK   <= 1'b0;
    end else begin
      cnt_reg <= cnt_reg + 10'd1;
      MCLK    <= cnt_reg[1] ^ cnt_reg[0];
      SCLK    <= cnt_reg[3] ^ (&cnt_reg[2:0]);
      LRCLK   <= cnt_reg[9] ^ (&cnt_reg[8:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RST;
      RSTn      <= 1'b0;
    end else if (frame_start) begin
      case (state_reg)
        ST_RST: begin
          state_reg <= ST_SYNC;
          RSTn      <= 1'b1;
        end
        ST_SYNC: state_reg <= ST_RUN;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  // Channel 0 is left (LRCLK low), channel 1 is right (LRCLK high).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [DW-1:0] sr_reg;
      logic [DW-1:0] tx_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_reg <= '0;
          tx_reg <= '0;
        end else begin
          if (sclk_rise && rx_win && (cnt_reg[9] == 1'(gi)))
            sr_reg <= {sr_reg[DW-2:0], SDout};
          if (frame_start)
            tx_reg <= tx_src[gi];
        end
      end

      assign sr_word[gi] = sr_reg;
      assign tx_word[gi] = tx_reg;
    end
  endgenerate

  // The right LSB arrives on the same edge that completes the frame, so it bypasses the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_in <= '0;
      rht_in <= '0;
      vld    <= 1'b0;
    end else begin
      vld <= rx_done;
      if (rx_done) begin
        lft_in <= sr_word[0];
        rht_in <= {sr_word[1][DW-2:0], SDout};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SDin <= 1'b0;
    end else if (sclk_fall) begin
      if ((state_reg == ST_RUN) && tx_win)
        SDin <= cnt_reg[9] ? tx_word[1][tx_idx] : tx_word[0][tx_idx];
      else
        SDin <= 1'b0;
    end
  end

endmodule
